// File: rtl/count_source.sv
// Runtime-prescaled up-counter with start/stop/clear/load control that feeds
// the blinker stage's currentCount input.

module count_source #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  oneshot,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      current_count,
    output logic                  wrap_tick,
    output logic                  running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic                    wrap_q, wrap_d;
    logic                    running_q, running_d;

    logic active;
    logic step;
    logic at_max;
    logic wrap_now;

    // A stop sampled in RUN freezes both the prescaler and the count that cycle.
    always_comb begin
        active   = (state_q == RUN) && !stop;
        step     = active && (pre_cnt_q >= prescale);
        at_max   = &count_q;
        wrap_now = step && at_max && !clear && !load;
    end

    always_comb begin
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        if (clear) begin
            count_d   = '0;
            pre_cnt_d = '0;
        end else if (load) begin
            count_d   = load_value;
            pre_cnt_d = '0;
        end else if (step) begin
            pre_cnt_d = '0;
            if (!(at_max && oneshot)) begin
                count_d = count_q + 1'b1;
            end
        end else if (active) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    // Stop beats start everywhere; clear only moves the FSM when it is parked in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (wrap_now && oneshot) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end else if (clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wrap_d    = wrap_now;
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign current_count = count_q;
    assign wrap_tick     = wrap_q;
    assign running       = running_q;

endmodule

// File: tb/tb_count_source.sv
// Self-checking bench for count_source: directed scenarios plus randomized
// control traffic checked against a cycle-level behavioural model.

module tb_count_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, clear, load, oneshot;
    logic [15:0] load_value;
    logic [7:0]  prescale;
    logic [15:0] current_count;
    logic        wrap_tick;
    logic        running;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: mode 0 = idle, 1 = counting, 2 = finished one-shot
    int          m_mode;
    int unsigned m_count;
    int unsigned m_phase;
    bit          m_wrap;

    count_source #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .clear         (clear),
        .load          (load),
        .load_value    (load_value),
        .oneshot       (oneshot),
        .prescale      (prescale),
        .current_count (current_count),
        .wrap_tick     (wrap_tick),
        .running       (running)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode  = 0;
        m_count = 0;
        m_phase = 0;
        m_wrap  = 0;
    endfunction

    function automatic void model_edge();
        bit go;
        bit stepping;
        bit wrapped;
        int next_mode;
        go        = (m_mode == 1) && !stop;
        stepping  = go && (m_phase >= int'(prescale));
        wrapped   = 0;
        next_mode = m_mode;
        if (clear) begin
            m_count = 0;
            m_phase = 0;
        end else if (load) begin
            m_count = load_value;
            m_phase = 0;
        end else if (stepping) begin
            m_phase = 0;
            if (m_count == 65535) begin
                wrapped = 1;
                if (!oneshot) m_count = 0;
            end else begin
                m_count = m_count + 1;
            end
        end else if (go) begin
            m_phase = m_phase + 1;
        end
        if (m_mode == 1) begin
            if (stop) next_mode = 0;
            else if (wrapped && oneshot) next_mode = 2;
        end else begin
            if (start && !stop) next_mode = 1;
            else if (m_mode == 2 && clear) next_mode = 0;
        end
        m_mode = next_mode;
        m_wrap = wrapped;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clear = 0; load = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); oneshot = 0; prescale = 0; load_value = 16'h0000;
        tick(); tick();
        n_checks++;
        if (current_count !== 16'h0000) $display("[TB] FAIL reset_count: got %h expected 0000", current_count);
        else n_pass++;
        n_checks++;
        if (running !== 1'b0) $display("[TB] FAIL reset_running: got %b expected 0", running);
        else n_pass++;
        n_checks++;
        if (wrap_tick !== 1'b0) $display("[TB] FAIL reset_wrap: got %b expected 0", wrap_tick);
        else n_pass++;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_count_basic();
        prescale = 0; oneshot = 0;
        start = 1; tick(); start = 0;
        n_checks++;
        if (running !== 1'b1 || current_count !== 16'h0000)
            $display("[TB] FAIL start_latency: got run=%b cnt=%h expected run=1 cnt=0000", running, current_count);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (current_count !== 16'(i)) $display("[TB] FAIL step_p0: got %h expected %h", current_count, 16'(i));
            else n_pass++;
        end
        prescale = 3;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (current_count !== 16'(3 + i / 4)) $display("[TB] FAIL step_p3: got %h expected %h", current_count, 16'(3 + i / 4));
            else n_pass++;
        end
        stop = 1; tick(); stop = 0;
        n_checks++;
        if (running !== 1'b0 || current_count !== 16'h0005)
            $display("[TB] FAIL stop_hold: got run=%b cnt=%h expected run=0 cnt=0005", running, current_count);
        else n_pass++;
    endtask

    task automatic test_wrap_freerun();
        logic [15:0] exp_cnt [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        logic        exp_wrap [3] = '{1'b0, 1'b1, 1'b0};
        load_value = 16'hFFFE; load = 1; tick(); load = 0;
        oneshot = 0; prescale = 0; start = 1; tick(); start = 0;
        n_checks++;
        if (current_count !== 16'hFFFE) $display("[TB] FAIL free_load: got %h expected FFFE", current_count);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (current_count !== exp_cnt[i] || wrap_tick !== exp_wrap[i] || running !== 1'b1)
                $display("[TB] FAIL free_wrap: got cnt=%h wrap=%b run=%b expected cnt=%h wrap=%b run=1",
                         current_count, wrap_tick, running, exp_cnt[i], exp_wrap[i]);
            else n_pass++;
        end
        stop = 1; tick(); stop = 0;
    endtask

    task automatic test_wrap_oneshot();
        load_value = 16'hFFFE; load = 1; tick(); load = 0;
        oneshot = 1; prescale = 0; start = 1; tick(); start = 0;
        tick();
        n_checks++;
        if (current_count !== 16'hFFFF || wrap_tick !== 1'b0)
            $display("[TB] FAIL os_pre: got cnt=%h wrap=%b expected cnt=FFFF wrap=0", current_count, wrap_tick);
        else n_pass++;
        tick();
        n_checks++;
        if (current_count !== 16'hFFFF || wrap_tick !== 1'b1 || running !== 1'b0)
            $display("[TB] FAIL os_wrap: got cnt=%h wrap=%b run=%b expected cnt=FFFF wrap=1 run=0",
                     current_count, wrap_tick, running);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (current_count !== 16'hFFFF || wrap_tick !== 1'b0 || running !== 1'b0)
                $display("[TB] FAIL os_done_hold: got cnt=%h wrap=%b run=%b expected cnt=FFFF wrap=0 run=0",
                         current_count, wrap_tick, running);
            else n_pass++;
        end
        clear = 1; tick(); clear = 0;
        n_checks++;
        if (current_count !== 16'h0000 || running !== 1'b0)
            $display("[TB] FAIL os_clear: got cnt=%h run=%b expected cnt=0000 run=0", current_count, running);
        else n_pass++;
        oneshot = 0; start = 1; tick(); start = 0;
        tick();
        n_checks++;
        if (current_count !== 16'h0001 || running !== 1'b1)
            $display("[TB] FAIL os_restart: got cnt=%h run=%b expected cnt=0001 run=1", current_count, running);
        else n_pass++;
        stop = 1; tick(); stop = 0;
    endtask

    task automatic test_async_reset();
        load_value = 16'h1234; load = 1; tick(); load = 0;
        prescale = 8'd200; start = 1; tick(); start = 0;
        n_checks++;
        if (current_count !== 16'h1234 || running !== 1'b1)
            $display("[TB] FAIL ar_setup: got cnt=%h run=%b expected cnt=1234 run=1", current_count, running);
        else n_pass++;
        #2 rst = 1;
        #1;
        model_reset();
        n_checks++;
        if (current_count !== 16'h0000 || running !== 1'b0 || wrap_tick !== 1'b0)
            $display("[TB] FAIL ar_immediate: got cnt=%h run=%b wrap=%b expected 0000 0 0",
                     current_count, running, wrap_tick);
        else n_pass++;
        @(negedge clk);
        rst = 0; prescale = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (current_count !== 16'h0000 || running !== 1'b0)
                $display("[TB] FAIL ar_after: got cnt=%h run=%b expected cnt=0000 run=0", current_count, running);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        prescale = 0; oneshot = 0;
        start = 1; tick(); start = 0;
        tick(); tick();
        stop = 1; start = 1; tick(); stop = 0; start = 0;
        n_checks++;
        if (current_count !== 16'h0002 || running !== 1'b0)
            $display("[TB] FAIL stop_start: got cnt=%h run=%b expected cnt=0002 run=0", current_count, running);
        else n_pass++;
        load_value = 16'h00AA; clear = 1; load = 1; start = 1; tick();
        clear = 0; load = 0; start = 0;
        n_checks++;
        if (current_count !== 16'h0000 || running !== 1'b1)
            $display("[TB] FAIL clr_ld_start: got cnt=%h run=%b expected cnt=0000 run=1", current_count, running);
        else n_pass++;
        stop = 1; tick(); stop = 0;
    endtask

    task automatic test_prescale_change();
        logic [15:0] exp_cnt [7] = '{16'h1, 16'h1, 16'h1, 16'h2, 16'h2, 16'h2, 16'h3};
        clear = 1; tick(); clear = 0;
        prescale = 8'd10; start = 1; tick(); start = 0;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (current_count !== 16'h0000) $display("[TB] FAIL pc_wait: got %h expected 0000", current_count);
        else n_pass++;
        prescale = 8'd2;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (current_count !== exp_cnt[i]) $display("[TB] FAIL pc_step: got %h expected %h", current_count, exp_cnt[i]);
            else n_pass++;
        end
        stop = 1; tick(); stop = 0;
    endtask

    task automatic test_random();
        logic [15:0] e_cnt;
        logic        e_run, e_wrap;
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 9) < 2);
            stop  = ($urandom_range(0, 19) == 0);
            clear = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 19) == 0);
            if (clear) start = 0;
            load_value = 16'hFFF0 + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) oneshot = ~oneshot;
            if ($urandom_range(0, 7) == 0) prescale = 8'($urandom_range(0, 3));
            tick();
            e_cnt  = 16'(m_count);
            e_run  = (m_mode == 1);
            e_wrap = m_wrap;
            n_checks++;
            if (current_count !== e_cnt || running !== e_run || wrap_tick !== e_wrap)
                $display("[TB] FAIL random_cycle%0d: got cnt=%h run=%b wrap=%b expected cnt=%h run=%b wrap=%b",
                         i, current_count, running, wrap_tick, e_cnt, e_run, e_wrap);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_basic();
        test_wrap_freerun();
        test_wrap_oneshot();
        test_async_reset();
        test_back_to_back();
        test_prescale_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
